// File: rtl/link_flit_buffer.sv
// rtl/link_flit_buffer.sv - packet-aware link input buffer with Req/Ack or credit flow control
module link_flit_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 8,
  parameter int CREDIT_MODE    = 0,
  parameter int INIT_CREDITS   = 8,
  parameter int MAX_PACKET_LEN = 8,
  parameter int LEN_LSB        = 0
) (
  input  logic                         Clock,
  input  logic                         nReset,
  input  logic                         S_Req,
  output logic                         S_Ack,
  input  logic [DATA_WIDTH-1:0]        S_Data,
  output logic                         S_Credit,
  output logic                         M_Req,
  input  logic                         M_Ack,
  output logic [DATA_WIDTH-1:0]        M_Data,
  output logic                         M_Last,
  input  logic                         M_Credit,
  output logic [$clog2(DEPTH+1)-1:0]   Level,
  output logic [$clog2(DEPTH+1)-1:0]   Pkt_Count,
  output logic                         Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(MAX_PACKET_LEN + 1);
  localparam int KW = $clog2(INIT_CREDITS + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [LW-1:0] MAX_LEN_C = LW'(MAX_PACKET_LEN);
  localparam logic [KW-1:0] INIT_C    = KW'(INIT_CREDITS);
  localparam logic [LW-1:0] ONE_LEN   = LW'(1);

  typedef enum logic {
    HEADER = 1'b0,
    BODY   = 1'b1
  } frame_state_t;

  // storage: flit plus tail marker in the top bit
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   level_q, pkt_q;
  logic [KW-1:0]   credits_q, credits_d;
  logic [KW:0]     credit_sum;
  logic            ovf_q, s_credit_q;
  logic            full, empty;
  logic            wr_en, rd_en, drop;
  logic            tail_bit;
  logic            tail_wr, tail_rd;
  logic [DATA_WIDTH:0] head;

  frame_state_t    state_q, state_d;
  logic [LW-1:0]   remaining_q, remaining_d;
  logic [LW-1:0]   hdr_len;

  assign full    = (level_q == DEPTH_C);
  assign empty   = (level_q == '0);
  assign head    = mem[rd_ptr];
  assign hdr_len = S_Data[LEN_LSB +: LW];
  assign tail_wr = wr_en & tail_bit;
  assign tail_rd = rd_en & head[DATA_WIDTH];

  // port handshakes: which flavour of flow control decides write and pop
  always_comb begin
    S_Ack = 1'b0;
    M_Req = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    drop  = 1'b0;
    if (CREDIT_MODE != 0) begin
      // upstream trusts its credits, so a flit arriving while full is lost
      wr_en = S_Req & ~full;
      drop  = S_Req & full;
      M_Req = ~empty & (credits_q != '0);
      rd_en = M_Req;
    end else begin
      // full refuses even if a pop happens this cycle: no bypass path
      S_Ack = S_Req & ~full;
      wr_en = S_Ack;
      M_Req = ~empty;
      rd_en = M_Req & M_Ack;
    end
  end

  // downstream credit counter, saturating at the downstream buffer depth
  always_comb begin
    credit_sum = {1'b0, credits_q} + {{KW{1'b0}}, M_Credit} - {{KW{1'b0}}, rd_en};
    credits_d  = credits_q;
    if (CREDIT_MODE != 0) begin
      if (credit_sum > {1'b0, INIT_C}) begin
        credits_d = INIT_C;
      end else begin
        credits_d = credit_sum[KW-1:0];
      end
    end
  end

  // framer next state: header length sets the body count, last body flit is the tail
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tail_bit    = 1'b0;
    case (state_q)
      HEADER: begin
        if ((hdr_len <= ONE_LEN) || (hdr_len > MAX_LEN_C)) begin
          // zero, one or out-of-range length: treat as a single-flit packet
          tail_bit = 1'b1;
        end else if (wr_en) begin
          remaining_d = hdr_len - ONE_LEN;
          state_d     = BODY;
        end
      end
      BODY: begin
        tail_bit = (remaining_q == ONE_LEN);
        if (wr_en) begin
          remaining_d = remaining_q - ONE_LEN;
          if (tail_bit) begin
            state_d = HEADER;
          end
        end
      end
      default: begin
        state_d = HEADER;
      end
    endcase
  end

  // framer state register
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q     <= HEADER;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // storage array write; contents are not reset
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= {tail_bit, S_Data};
    end
  end

  // pointers, occupancy and complete-packet count
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      pkt_q   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + CW'(1);
        2'b01:   level_q <= level_q - CW'(1);
        default: level_q <= level_q;
      endcase
      case ({tail_wr, tail_rd})
        2'b10:   pkt_q <= pkt_q + CW'(1);
        2'b01:   pkt_q <= pkt_q - CW'(1);
        default: pkt_q <= pkt_q;
      endcase
    end
  end

  // credit bookkeeping, upstream credit return and sticky overflow flag
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      credits_q  <= INIT_C;
      s_credit_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      s_credit_q <= rd_en & (CREDIT_MODE != 0);
      ovf_q      <= ovf_q | drop;
    end
  end

  assign M_Data    = empty ? '0 : head[DATA_WIDTH-1:0];
  assign M_Last    = ~empty & head[DATA_WIDTH];
  assign Level     = level_q;
  assign Pkt_Count = pkt_q;
  assign Overflow  = ovf_q;
  assign S_Credit  = s_credit_q;

endmodule

// File: tb/tb_link_flit_buffer.sv
// tb/tb_link_flit_buffer.sv - bench for link_flit_buffer in Req/Ack and credit modes
module tb_link_flit_buffer;

  localparam int DW      = 32;
  localparam int DEPTH   = 8;
  localparam int MAXL    = 8;
  localparam int LW      = 4;
  localparam int CW      = 4;
  localparam int CR_INIT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic          ra_s_req, ra_s_ack, ra_s_credit, ra_m_req, ra_m_ack, ra_m_last, ra_m_credit, ra_ovf;
  logic [DW-1:0] ra_s_data, ra_m_data;
  logic [CW-1:0] ra_level, ra_pkt;

  logic          cr_s_req, cr_s_ack, cr_s_credit, cr_m_req, cr_m_ack, cr_m_last, cr_m_credit, cr_ovf;
  logic [DW-1:0] cr_s_data, cr_m_data;
  logic [CW-1:0] cr_level, cr_pkt;

  link_flit_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .CREDIT_MODE(0), .INIT_CREDITS(8),
    .MAX_PACKET_LEN(MAXL), .LEN_LSB(0)
  ) u_ra (
    .Clock(clk), .nReset(rstn),
    .S_Req(ra_s_req), .S_Ack(ra_s_ack), .S_Data(ra_s_data), .S_Credit(ra_s_credit),
    .M_Req(ra_m_req), .M_Ack(ra_m_ack), .M_Data(ra_m_data), .M_Last(ra_m_last),
    .M_Credit(ra_m_credit), .Level(ra_level), .Pkt_Count(ra_pkt), .Overflow(ra_ovf)
  );

  link_flit_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .CREDIT_MODE(1), .INIT_CREDITS(CR_INIT),
    .MAX_PACKET_LEN(MAXL), .LEN_LSB(0)
  ) u_cr (
    .Clock(clk), .nReset(rstn),
    .S_Req(cr_s_req), .S_Ack(cr_s_ack), .S_Data(cr_s_data), .S_Credit(cr_s_credit),
    .M_Req(cr_m_req), .M_Ack(cr_m_ack), .M_Data(cr_m_data), .M_Last(cr_m_last),
    .M_Credit(cr_m_credit), .Level(cr_level), .Pkt_Count(cr_pkt), .Overflow(cr_ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference state: queues of {tail, flit}
  logic [DW:0] ra_q[$];
  logic [DW:0] cr_q[$];
  int ra_rem = 0;
  int cr_rem = 0;
  int cr_credits = CR_INIT;
  bit cr_ovf_m = 1'b0;
  bit cr_scred_m = 1'b0;
  int n_cr_mreq = 0;
  int n_cr_scred = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // packet framing from the header length rule; rem counts body flits still due
  function automatic bit frame_tail(input logic [DW-1:0] d, inout int rem);
    int len;
    if (rem == 0) begin
      len = int'(d[LW-1:0]);
      if (len <= 1 || len > MAXL) return 1'b1;
      rem = len - 1;
      return 1'b0;
    end
    rem = rem - 1;
    return (rem == 0);
  endfunction

  task automatic idle_inputs();
    ra_s_req = 0; ra_s_data = '0; ra_m_ack = 0; ra_m_credit = 0;
    cr_s_req = 0; cr_s_data = '0; cr_m_ack = 0; cr_m_credit = 0;
  endtask

  // called at a negedge with inputs set: check outputs, advance model, move to next negedge
  task automatic tick();
    int ra_pk, cr_pk;
    bit e_ra_sack, e_ra_mreq, e_cr_mreq, ra_pop, ra_wr, cr_pop, cr_wr, t;
    logic [DW:0] ra_head, cr_head;
    #1;
    e_ra_sack = ra_s_req && (ra_q.size() < DEPTH);
    e_ra_mreq = (ra_q.size() != 0);
    ra_head   = e_ra_mreq ? ra_q[0] : '0;
    ra_pk = 0;
    foreach (ra_q[i]) if (ra_q[i][DW]) ra_pk++;
    check("ra_s_ack", ra_s_ack, e_ra_sack);
    check("ra_m_req", ra_m_req, e_ra_mreq);
    check("ra_m_data", ra_m_data, ra_head[DW-1:0]);
    check("ra_m_last", ra_m_last, ra_head[DW]);
    check("ra_level", ra_level, ra_q.size());
    check("ra_pkt_count", ra_pkt, ra_pk);
    check("ra_s_credit", ra_s_credit, 0);
    check("ra_overflow", ra_ovf, 0);

    e_cr_mreq = (cr_q.size() != 0) && (cr_credits > 0);
    cr_head   = (cr_q.size() != 0) ? cr_q[0] : '0;
    cr_pk = 0;
    foreach (cr_q[i]) if (cr_q[i][DW]) cr_pk++;
    check("cr_s_ack", cr_s_ack, 0);
    check("cr_m_req", cr_m_req, e_cr_mreq);
    check("cr_m_data", cr_m_data, cr_head[DW-1:0]);
    check("cr_m_last", cr_m_last, cr_head[DW]);
    check("cr_level", cr_level, cr_q.size());
    check("cr_pkt_count", cr_pkt, cr_pk);
    check("cr_overflow", cr_ovf, cr_ovf_m);
    check("cr_s_credit", cr_s_credit, cr_scred_m);
    if (cr_m_req) n_cr_mreq++;
    if (cr_s_credit) n_cr_scred++;

    if (!rstn) begin
      ra_q.delete(); cr_q.delete();
      ra_rem = 0; cr_rem = 0;
      cr_credits = CR_INIT; cr_ovf_m = 0; cr_scred_m = 0;
    end else begin
      ra_pop = e_ra_mreq && ra_m_ack;
      ra_wr  = e_ra_sack;
      t = 0;
      if (ra_wr) t = frame_tail(ra_s_data, ra_rem);
      if (ra_pop) void'(ra_q.pop_front());
      if (ra_wr) ra_q.push_back({t, ra_s_data});

      cr_pop = e_cr_mreq;
      cr_wr  = cr_s_req && (cr_q.size() < DEPTH);
      if (cr_s_req && !cr_wr) cr_ovf_m = 1;
      t = 0;
      if (cr_wr) t = frame_tail(cr_s_data, cr_rem);
      if (cr_pop) void'(cr_q.pop_front());
      if (cr_wr) cr_q.push_back({t, cr_s_data});
      cr_credits = cr_credits - int'(cr_pop) + int'(cr_m_credit);
      if (cr_credits > CR_INIT) cr_credits = CR_INIT;
      cr_scred_m = cr_pop;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // reset state and a single-flit packet through the Req/Ack side
    ra_s_req = 1; ra_s_data = 32'h0000_0001; ra_m_ack = 1;
    tick();
    ra_s_req = 0;
    check("t1_m_last", ra_m_last, 1);
    check("t1_pkt_before_pop", ra_pkt, 1);
    tick();
    check("t1_pkt_after_pop", ra_pkt, 0);
    tick();

    // fill past capacity with no acknowledge, then drain in order
    ra_m_ack = 0;
    for (int i = 0; i < 9; i++) begin
      ra_s_req = 1; ra_s_data = {i[23:0], 8'h01};
      if (i == 8) check("t2_s_ack_full", ra_s_ack, 0);
      tick();
    end
    ra_s_req = 0;
    check("t2_level_full", ra_level, 8);
    ra_m_ack = 1;
    for (int i = 0; i < 10; i++) tick();
    check("t2_level_drained", ra_level, 0);

    // three-flit packet, then out-of-range lengths 0 and 9
    ra_m_ack = 0;
    ra_s_req = 1; ra_s_data = 32'hA000_0003; tick();
    ra_s_data = 32'hB000_0012; tick();
    check("t3_pkt_mid", ra_pkt, 0);
    ra_s_data = 32'hC000_0034; tick();
    check("t3_pkt_done", ra_pkt, 1);
    ra_s_data = 32'hD000_0000; tick();
    ra_s_data = 32'hE000_0009; tick();
    ra_s_req = 0;
    check("t3_pkt_singles", ra_pkt, 3);
    ra_m_ack = 1;
    for (int i = 0; i < 6; i++) tick();
    ra_m_ack = 0;

    // credit mode: two initial credits release exactly two flits
    n_cr_mreq = 0; n_cr_scred = 0;
    for (int i = 0; i < 4; i++) begin
      cr_s_req = 1; cr_s_data = {i[23:0], 8'h11}; tick();
    end
    cr_s_req = 0;
    for (int i = 0; i < 4; i++) tick();
    check("t4_mreq_two_credits", n_cr_mreq, 2);
    cr_m_credit = 1; tick();
    cr_m_credit = 0;
    for (int i = 0; i < 4; i++) tick();
    check("t4_mreq_after_return", n_cr_mreq, 3);
    check("t4_s_credit_pulses", n_cr_scred, 3);
    check("t4_level_left", cr_level, 1);

    // send the leftover flit, then overrun the full buffer with no credits
    cr_m_credit = 1; tick();
    cr_m_credit = 0; tick(); tick();
    for (int i = 0; i < 9; i++) begin
      cr_s_req = 1; cr_s_data = {8'h5A, i[15:0], 8'h01}; tick();
    end
    cr_s_req = 0;
    check("t5_overflow", cr_ovf, 1);
    check("t5_level", cr_level, 8);
    cr_m_credit = 1;
    for (int i = 0; i < 12; i++) tick();
    cr_m_credit = 0;
    check("t5_level_drained", cr_level, 0);
    check("t5_overflow_sticky", cr_ovf, 1);

    // reset in the middle of an L=4 packet
    ra_s_req = 1; ra_s_data = 32'h0000_0A04; tick();
    ra_s_data = 32'h0000_0B07; tick();
    ra_s_req = 0; rstn = 0; tick();
    rstn = 1;
    check("t6_level", ra_level, 0);
    check("t6_m_req", ra_m_req, 0);
    check("t6_m_data", ra_m_data, 0);
    ra_s_req = 1; ra_s_data = 32'h0000_0C01; tick();
    ra_s_req = 0;
    check("t6_header_after_reset", ra_m_last, 1);
    ra_m_ack = 1; tick(); tick();

    // randomized traffic with varying back-pressure and occasional resets
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 500; i++) begin
        logic [DW-1:0] d1, d2;
        rstn        = ($urandom_range(0, 299) != 0);
        d1          = $urandom;
        d1[3:0]     = 4'($urandom_range(0, 10));
        d2          = $urandom;
        d2[3:0]     = 4'($urandom_range(0, 10));
        ra_s_req    = ($urandom_range(0, 9) < 6);
        ra_s_data   = d1;
        ra_m_ack    = ($urandom_range(0, 3) < p + 1) && ($urandom_range(0, 1) == 1 || p == 3);
        ra_m_credit = $urandom_range(0, 1);
        cr_s_req    = ($urandom_range(0, 9) < 3 + p);
        cr_s_data   = d2;
        cr_m_ack    = $urandom_range(0, 1);
        cr_m_credit = ($urandom_range(0, 9) < 2 + p);
        tick();
      end
    end
    rstn = 1;
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
